// File: rtl/xpb_digit_accum.sv
// xpb_digit_accum: walks the upper coefficient word one digit per cycle through the
// registered xpb LUT bank and accumulates the returned values onto the lower-part seed.
module xpb_digit_accum #(
    parameter int DIGIT_BITS = 5,
    parameter int NUM_DIGITS = 8,
    parameter int WIDTH      = 1024,
    parameter int SEL_BITS   = $clog2(NUM_DIGITS),
    parameter int ACC_BITS   = WIDTH + $clog2(NUM_DIGITS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             ready,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] upper_in,
    input  logic [WIDTH-1:0]                 base_in,
    output logic [SEL_BITS-1:0]              lut_sel,
    output logic [DIGIT_BITS-1:0]            lut_idx,
    input  logic [WIDTH-1:0]                 lut_data,
    output logic                             done,
    output logic [ACC_BITS-1:0]              sum_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [SEL_BITS-1:0] cnt;
    logic [NUM_DIGITS*DIGIT_BITS-1:0] digits;
    logic pipe;
    logic [ACC_BITS-1:0] acc, acc_add;
    // pipe marks cycles where lut_data answers a lookup issued one cycle earlier
    assign acc_add = pipe ? acc + ACC_BITS'(lut_data) : acc;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = start ? ISSUE : IDLE;
            ISSUE: state_nx = (cnt == SEL_BITS'(NUM_DIGITS - 1)) ? DRAIN : ISSUE;
            DRAIN: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        ready   = state == IDLE;
        done    = state == DONE;
        lut_sel = (state == ISSUE) ? cnt : '0;
        lut_idx = (state == ISSUE) ? digits[DIGIT_BITS-1:0] : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            digits  <= '0;
            pipe    <= 1'b0;
            acc     <= '0;
            sum_out <= '0;
        end else begin
            state <= state_nx;
            pipe  <= state == ISSUE;
            if (state == IDLE && start) begin
                digits <= upper_in;
                acc    <= ACC_BITS'(base_in);
                cnt    <= '0;
            end else begin
                acc <= acc_add;
            end
            if (state == ISSUE) begin
                cnt    <= cnt + 1'b1;
                digits <= digits >> DIGIT_BITS;
            end
            if (state == DRAIN)
                sum_out <= acc_add;
        end
    end
endmodule

// File: tb/tb_xpb_digit_accum.sv
// tb_xpb_digit_accum: directed and randomized checks of the digit accumulator against
// a registered LUT model and an arithmetic reference sum.
module tb_xpb_digit_accum;
    localparam int DB = 5, ND = 8, W = 1024, SB = 3, AB = 1028;
    logic clk = 0, rst = 0, start = 0;
    logic ready, done;
    logic [ND*DB-1:0] upper_in = '0;
    logic [W-1:0] base_in = '0;
    logic [SB-1:0] lut_sel;
    logic [DB-1:0] lut_idx;
    logic [W-1:0] lut_data = '0;
    logic [AB-1:0] sum_out;
    logic [W-1:0] lut_tab [ND][32];
    int n_cmp = 0, n_err = 0;

    xpb_digit_accum dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .upper_in(upper_in), .base_in(base_in),
        .lut_sel(lut_sel), .lut_idx(lut_idx), .lut_data(lut_data),
        .done(done), .sum_out(sum_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) lut_data <= lut_tab[lut_sel][lut_idx];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [AB-1:0] obs, input logic [AB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h_..%h expected=%h_..%h", tag,
                   obs[AB-1:W], obs[127:0], exp[AB-1:W], exp[127:0]);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic fill(input int mode);
        for (int s = 0; s < ND; s++)
            for (int i = 0; i < 32; i++)
                lut_tab[s][i] = (mode == 0) ? W'(i) : (mode == 1) ? {W{1'b1}} : rnd_w();
    endtask

    function automatic logic [AB-1:0] model(input logic [ND*DB-1:0] up, input logic [W-1:0] base);
        logic [AB-1:0] s;
        s = AB'(base);
        for (int k = 0; k < ND; k++) s = s + AB'(lut_tab[k][up[k*DB +: DB]]);
        return s;
    endfunction

    // Starts (unless pre already holds start high), walks the fixed-latency schedule
    // and returns in cycle T+11 of the operation.
    task automatic run_op(input logic [ND*DB-1:0] up, input logic [W-1:0] base, input bit pre,
                          input int busy_at, input bit hold,
                          input logic [ND*DB-1:0] nup, input logic [W-1:0] nbase);
        logic [AB-1:0] exp;
        exp = model(up, base);
        if (!pre) begin
            upper_in = up;
            base_in  = base;
            start    = 1;
        end
        tick();
        start    = 0;
        upper_in = $urandom;
        base_in  = rnd_w();
        for (int k = 0; k < ND; k++) begin
            start = (busy_at == k + 1);
            chk("issue_sel", AB'(lut_sel), AB'(k));
            chk("issue_idx", AB'(lut_idx), AB'(up[k*DB +: DB]));
            chk("issue_busy", AB'({ready, done}), AB'(0));
            tick();
        end
        start = 0;
        chk("drain_done", AB'({ready, done, lut_sel, lut_idx}), AB'(0));
        tick();
        chk("done_pulse", AB'({ready, done}), AB'(1));
        chk("sum", sum_out, exp);
        if (hold) begin
            upper_in = nup;
            base_in  = nbase;
            start    = 1;
        end
        tick();
        chk("after_done", AB'({ready, done}), AB'(2));
        chk("sum_held", sum_out, exp);
    endtask

    initial begin
        logic [ND*DB-1:0] up;
        logic [W-1:0] b;
        fill(0);
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_ready_done", AB'({ready, done}), AB'(2));
        chk("rst_sum", sum_out, '0);
        chk("rst_lut", AB'({lut_sel, lut_idx}), AB'(0));

        for (int k = 0; k < ND; k++) up[k*DB +: DB] = DB'(k + 1);
        run_op(up, '0, 0, 0, 0, '0, '0);
        chk("digit_order_sum", sum_out, AB'(36));

        run_op('0, W'(5), 0, 0, 0, '0, '0);
        chk("zero_digits_sum", sum_out, AB'(5));

        fill(1);
        run_op({ND*DB{1'b1}}, {W{1'b1}}, 0, 0, 0, '0, '0);
        chk("headroom_top", AB'(sum_out[AB-1:W]), AB'(4'b1000));

        fill(2);
        for (int r = 0; r < 4; r++) run_op({$urandom, $urandom}, rnd_w(), 0, 0, 0, '0, '0);

        up = {$urandom, $urandom};
        b  = rnd_w();
        run_op({$urandom, $urandom}, rnd_w(), 0, 3, 1, up, b);
        run_op(up, b, 1, 0, 0, '0, '0);

        rst   = 1;
        start = 1;
        tick();
        rst   = 0;
        start = 0;
        chk("rst_start_ready", AB'(ready), AB'(1));
        tick();
        chk("rst_start_dropped", AB'(ready), AB'(1));

        fill(0);
        upper_in = {ND{5'h1b}};
        base_in  = rnd_w();
        start    = 1;
        tick();
        start = 0;
        for (int c = 1; c < 4; c++) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_state", AB'({ready, done, lut_sel, lut_idx}), AB'(1 << 9));
        chk("midrst_sum", sum_out, '0);
        run_op('0, W'(7), 0, 0, 0, '0, '0);
        chk("midrst_new_sum", sum_out, AB'(7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
